// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Data-memory bus between the MEM-stage access controller and data memory.
//   mem_req   : request outstanding (controller -> memory)
//   mem_we    : request is a write (controller -> memory)
//   mem_addr  : word-aligned byte address (controller -> memory)
//   mem_wdata : store data (controller -> memory)
//   mem_ack   : memory completes the outstanding request (memory -> controller)
//   mem_err   : memory reports a bus error (memory -> controller)
//   mem_rdata : read data, valid with mem_ack (memory -> controller)
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_rdata;

  // The controller side issues requests and consumes responses
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_err, mem_rdata
  );

  // The memory side consumes requests and produces responses
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_err, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Turns the MEM-stage load/store of a pipelined CPU into a request/acknowledge
// transaction on the data-memory bus, freezing the pipeline while the access
// is in flight and trapping into a terminal error state on illegal accesses,
// bus errors or a memory that never answers.
//
// Ports
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   MEM_MEM_REN/WEN  : MEM-stage instruction is a load / store
//   MEM_ALUResult    : byte address of the access
//   MEM_D2           : store data
//   mem              : data-memory bus (master side)
//   pipe_stall       : freezes PC, IF_ID, ID_EX and EX_MEM
//   wb_bubble        : forces MEM_WB to capture a no-op
//   load_data        : captured read data
//   load_valid       : load_data belongs to the MEM-stage instruction now
//   err_flag         : sticky fault indicator
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MEM_MEM_REN,
  input  logic              MEM_MEM_WEN,
  input  logic [31:0]       MEM_ALUResult,
  input  logic [31:0]       MEM_D2,
  mem_access_ctrl_if.master mem,
  output logic              pipe_stall,
  output logic              wb_bubble,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              err_flag
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_t;

  // Last counter value tolerated in REQ; reaching it without an answer means
  // the access has spent TIMEOUT cycles waiting.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] timeout_count;

  logic access;
  logic misaligned;
  logic illegal;

  assign access     = MEM_MEM_REN | MEM_MEM_WEN;
  assign misaligned = MEM_ALUResult[1:0] != 2'b00;
  assign illegal    = (MEM_MEM_REN & MEM_MEM_WEN) | misaligned;

  // Main controller FSM. All bus outputs, load_data, load_valid and err_flag
  // are registered here. The bus request fields are cleared again whenever
  // REQ is left, so the bus reads all-zero outside an active access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timeout_count <= 8'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'd0;
      mem.mem_wdata <= 32'd0;
      load_data     <= 32'd0;
      load_valid    <= 1'b0;
      err_flag      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_valid <= 1'b0;
          if (access) begin
            if (illegal) begin
              state    <= ERR;
              err_flag <= 1'b1;
            end else begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= MEM_MEM_WEN;
              mem.mem_addr  <= {MEM_ALUResult[31:2], 2'b00};
              mem.mem_wdata <= MEM_D2;
              timeout_count <= 8'd0;
              state         <= REQ;
            end
          end
        end

        REQ: begin
          // A bus error wins over a simultaneous acknowledge
          if (mem.mem_err) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
            err_flag      <= 1'b1;
            state         <= ERR;
          end else if (mem.mem_ack) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
            if (!mem.mem_we) begin
              load_data  <= mem.mem_rdata;
              load_valid <= 1'b1;
            end
            state <= DONE;
          end else if (timeout_count == TIMEOUT_LAST) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
            err_flag      <= 1'b1;
            state         <= ERR;
          end else begin
            timeout_count <= timeout_count + 8'd1;
          end
        end

        // One-cycle release so the pipeline advances on this edge
        DONE: begin
          load_valid <= 1'b0;
          state      <= IDLE;
        end

        ERR: begin
          state <= ERR;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pipeline hold decode. In IDLE the stall follows the incoming access
  // combinationally so the instruction cannot slip past before the request
  // goes out; an illegal access is held as well since it lands in ERR.
  always_comb begin
    pipe_stall = 1'b0;
    case (state)
      IDLE:    pipe_stall = access;
      REQ:     pipe_stall = 1'b1;
      ERR:     pipe_stall = 1'b1;
      default: pipe_stall = 1'b0;
    endcase
  end

  assign wb_bubble = pipe_stall;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum REQ-state cycles before an access is declared failed (range 2..255).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 MEM_MEM_REN  input  1  MEM-stage instruction is a load.
REQ-005 MEM_MEM_WEN  input  1  MEM-stage instruction is a store.
REQ-006 MEM_ALUResult  input  32  byte address of the access.
REQ-007 MEM_D2  input  32  store data.
REQ-008 mem_ack  input  1  memory completes the outstanding request.
REQ-009 mem_err  input  1  memory reports a bus error; qualified only together with mem_ack or alone in REQ.
REQ-010 mem_rdata  input  32  read data, valid with mem_ack.
REQ-011 mem_req  output  1  request to data memory, registered.
REQ-012 mem_we  output  1  request is a write, registered.
REQ-013 mem_addr  output  32  word-aligned request address, registered.
REQ-014 mem_wdata  output  32  write data, registered.
REQ-015 pipe_stall  output  1  freezes PC, IF_ID, ID_EX and EX_MEM.
REQ-016 wb_bubble  output  1  forces MEM_WB to capture a no-op.
REQ-017 load_data  output  32  captured read data.
REQ-018 load_valid  output  1  load_data belongs to the MEM-stage instruction this cycle.
REQ-019 err_flag  output  1  sticky fault indicator.

Function
REQ-020 States SHALL be IDLE, REQ, DONE, ERR; encoding free.
REQ-021 access = MEM_MEM_REN | MEM_MEM_WEN; misaligned = MEM_ALUResult[1:0] != 0.
REQ-022 IDLE, no access: all outputs low except load_data (hold); stay IDLE.
REQ-023 IDLE, access, REN and WEN both high or misaligned: next state ERR, no request issued.
REQ-024 IDLE, legal access: pipe_stall=1, wb_bubble=1 (combinational); on the edge latch mem_addr={MEM_ALUResult[31:2],2'b00}, mem_wdata=MEM_D2, mem_we=MEM_MEM_WEN, set mem_req=1, clear timeout counter, go REQ.
REQ-025 REQ: pipe_stall=1, wb_bubble=1, mem_req/mem_we/mem_addr/mem_wdata held stable until exit.
REQ-026 REQ, mem_ack=1 and mem_err=0: drop mem_req on the edge; if mem_we=0 latch load_data=mem_rdata; go DONE.
REQ-027 REQ, mem_err=1 (with or without mem_ack): go ERR; mem_err has priority over mem_ack.
REQ-028 REQ, no ack: increment 8-bit counter; when counter reaches TIMEOUT-1 without ack, go ERR on that edge (TIMEOUT cycles total in REQ).
REQ-029 DONE: pipe_stall=0, wb_bubble=0, load_valid=1 for loads only, exactly one cycle; next state IDLE unconditionally, so the pipeline advances on the DONE edge.
REQ-030 Minimum access latency: 3 cycles (IDLE, REQ with same-cycle ack, DONE); back-to-back accesses SHALL incur no extra idle cycle beyond that.
REQ-031 ERR: mem_req=0, pipe_stall=1, wb_bubble=1, err_flag=1; terminal until reset.
REQ-032 mem_ack or mem_err outside REQ SHALL be ignored.
REQ-033 Store completion SHALL leave load_data unchanged and load_valid=0.

Reset
REQ-034 Asserting reset at any time, including mid-REQ, SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, load_data=0, load_valid=0, err_flag=0, counter=0; pipe_stall and wb_bubble reflect IDLE decoding.
REQ-035 The first edge after reset deassertion SHALL evaluate inputs as IDLE.

Verification
REQ-036 Load: REN=1, ALUResult=0x100, ack in first REQ cycle with rdata=0xDEADBEEF -> mem_req one cycle, addr 0x100, we=0; DONE cycle load_valid=1, load_data=0xDEADBEEF; stall high exactly 2 cycles.
REQ-037 Store with 3-cycle ack delay: WEN=1, ALUResult=0x204, D2=0x12345678 -> mem_we=1, wdata stable for 3 REQ cycles, load_valid=0 in DONE, stall high 4 cycles.
REQ-038 Timeout: REN=1, never ack, TIMEOUT=16 -> exactly 16 REQ cycles then ERR, err_flag=1, stall held, mem_req=0.
REQ-039 Faults: ALUResult=0x102 -> ERR without any mem_req; REN=WEN=1 -> ERR; mem_ack=mem_err=1 in REQ -> ERR, load_data unchanged.
REQ-040 Reset mid-REQ at cycle 2 of a pending load -> mem_req low asynchronously, all outputs at reset values, subsequent legal load completes normally.
REQ-041 Two consecutive loads (0x10 then 0x14, ack immediate) -> two DONE cycles 3 cycles apart, correct data each, spurious mem_ack in IDLE/DONE ignored.
